// File: rtl/mem_arbiter_pkg.sv
// Shared types for the four-master Avalon memory arbiter.
package mem_arb_defs;

    typedef enum logic [1:0] {IDLE, ISSUE, DONE} mem_arb_state;
    typedef logic [1:0]   mem_arb_id;
    typedef logic [127:0] line;

    localparam int unsigned NumMasters = 4;

endpackage

// File: rtl/mem_arbiter_rr_pick4.sv
// Combinational round-robin picker: first requester after 'last', wrapping modulo 4.
module rr_pick4
    import mem_arb_defs::*;
(
    input  logic [3:0] req,
    input  mem_arb_id  last,
    output mem_arb_id  grant,
    output logic       any
);

    mem_arb_id cand;

    // Walk from farthest to nearest so the nearest requester after 'last' wins.
    always_comb begin
        grant = last;
        any   = 1'b0;
        cand  = last;
        for (int i = 4; i >= 1; i--) begin
            cand = last + 2'(i);
            if (req[cand]) begin
                grant = cand;
                any   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Four-to-one round-robin arbiter onto a single registered 128-bit Avalon port,
// one transaction outstanding at a time.
module mem_arbiter
    import mem_arb_defs::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic [31:0]  mem_0_address,
    input  logic         mem_0_read,
    input  logic         mem_0_write,
    input  logic [127:0] mem_0_writedata,
    input  logic [15:0]  mem_0_byteenable,
    output logic [127:0] mem_0_readdata,
    output logic         mem_0_waitrequest,
    input  logic [31:0]  mem_1_address,
    input  logic         mem_1_read,
    input  logic         mem_1_write,
    input  logic [127:0] mem_1_writedata,
    input  logic [15:0]  mem_1_byteenable,
    output logic [127:0] mem_1_readdata,
    output logic         mem_1_waitrequest,
    input  logic [31:0]  mem_2_address,
    input  logic         mem_2_read,
    input  logic         mem_2_write,
    input  logic [127:0] mem_2_writedata,
    input  logic [15:0]  mem_2_byteenable,
    output logic [127:0] mem_2_readdata,
    output logic         mem_2_waitrequest,
    input  logic [31:0]  mem_3_address,
    input  logic         mem_3_read,
    input  logic         mem_3_write,
    input  logic [127:0] mem_3_writedata,
    input  logic [15:0]  mem_3_byteenable,
    output logic [127:0] mem_3_readdata,
    output logic         mem_3_waitrequest,
    output logic [31:0]  avl_address,
    output logic         avl_read,
    output logic         avl_write,
    output logic [127:0] avl_writedata,
    output logic [15:0]  avl_byteenable,
    input  logic [127:0] avl_readdata,
    input  logic         avl_waitrequest
);

    logic [31:0] req_addr  [NumMasters];
    line         req_wdata [NumMasters];
    logic [15:0] req_be    [NumMasters];
    logic [3:0]  req_rd, req_wr, req_any, wait_n;
    line         rdata_q   [NumMasters];

    mem_arb_state state_q, state_d;
    mem_arb_id    last_q, grant_q, pick;
    logic         pick_any;

    logic [31:0]  avl_address_q;
    logic         avl_read_q, avl_write_q;
    line          avl_writedata_q;
    logic [15:0]  avl_byteenable_q;

    assign req_addr  = '{mem_0_address, mem_1_address, mem_2_address, mem_3_address};
    assign req_wdata = '{mem_0_writedata, mem_1_writedata, mem_2_writedata, mem_3_writedata};
    assign req_be    = '{mem_0_byteenable, mem_1_byteenable, mem_2_byteenable, mem_3_byteenable};
    assign req_rd    = {mem_3_read, mem_2_read, mem_1_read, mem_0_read};
    assign req_wr    = {mem_3_write, mem_2_write, mem_1_write, mem_0_write};
    assign req_any   = req_rd | req_wr;

    rr_pick4 u_pick (
        .req   (req_any),
        .last  (last_q),
        .grant (pick),
        .any   (pick_any)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (pick_any) state_d = ISSUE;
            ISSUE:   if (!avl_waitrequest) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Write wins when a master raises read and write together.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_q           <= 2'd3;
            grant_q          <= 2'd0;
            avl_address_q    <= '0;
            avl_read_q       <= 1'b0;
            avl_write_q      <= 1'b0;
            avl_writedata_q  <= '0;
            avl_byteenable_q <= '0;
            for (int i = 0; i < NumMasters; i++) rdata_q[i] <= '0;
        end else begin
            if (state_q == IDLE && pick_any) begin
                grant_q          <= pick;
                last_q           <= pick;
                avl_address_q    <= req_addr[pick];
                avl_write_q      <= req_wr[pick];
                avl_read_q       <= !req_wr[pick];
                avl_writedata_q  <= req_wdata[pick];
                avl_byteenable_q <= req_be[pick];
            end
            if (state_q == ISSUE && !avl_waitrequest) begin
                avl_read_q  <= 1'b0;
                avl_write_q <= 1'b0;
                if (avl_read_q) rdata_q[grant_q] <= avl_readdata;
            end
        end
    end

    always_comb begin
        wait_n = 4'hF;
        if (state_q == DONE) wait_n[grant_q] = 1'b0;
    end

    assign avl_address       = avl_address_q;
    assign avl_read          = avl_read_q;
    assign avl_write         = avl_write_q;
    assign avl_writedata     = avl_writedata_q;
    assign avl_byteenable    = avl_byteenable_q;
    assign mem_0_waitrequest = wait_n[0];
    assign mem_1_waitrequest = wait_n[1];
    assign mem_2_waitrequest = wait_n[2];
    assign mem_3_waitrequest = wait_n[3];
    assign mem_0_readdata    = rdata_q[0];
    assign mem_1_readdata    = rdata_q[1];
    assign mem_2_readdata    = rdata_q[2];
    assign mem_3_readdata    = rdata_q[3];

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: directed transactions queue expected bus and completion
// events; independent monitors pop and compare them as the DUT presents them.
module tb_mem_arbiter;
    import mem_arb_defs::*;

    typedef struct {
        logic [31:0] addr;
        logic        wr;
        line         wdata;
        logic [15:0] be;
    } exp_avl_t;

    typedef struct {
        int  id;
        logic rd;
        line data;
    } exp_cpl_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [31:0] m_addr  [4];
    logic        m_rd    [4];
    logic        m_wr    [4];
    line         m_wdata [4];
    logic [15:0] m_be    [4];
    line         m_rdata [4];
    logic        m_wait  [4];

    logic [31:0] avl_address;
    logic        avl_read, avl_write, avl_waitrequest;
    line         avl_writedata, avl_readdata;
    logic [15:0] avl_byteenable;

    int  stall_target = 0;
    logic rd_fix_en = 1'b0;
    line rd_fix = '0;

    exp_avl_t aq[$];
    exp_cpl_t cq[$];
    int n_pass  = 0;
    int n_total = 0;

    mem_arbiter dut (
        .clk               (clk),
        .rst               (rst),
        .mem_0_address     (m_addr[0]),
        .mem_0_read        (m_rd[0]),
        .mem_0_write       (m_wr[0]),
        .mem_0_writedata   (m_wdata[0]),
        .mem_0_byteenable  (m_be[0]),
        .mem_0_readdata    (m_rdata[0]),
        .mem_0_waitrequest (m_wait[0]),
        .mem_1_address     (m_addr[1]),
        .mem_1_read        (m_rd[1]),
        .mem_1_write       (m_wr[1]),
        .mem_1_writedata   (m_wdata[1]),
        .mem_1_byteenable  (m_be[1]),
        .mem_1_readdata    (m_rdata[1]),
        .mem_1_waitrequest (m_wait[1]),
        .mem_2_address     (m_addr[2]),
        .mem_2_read        (m_rd[2]),
        .mem_2_write       (m_wr[2]),
        .mem_2_writedata   (m_wdata[2]),
        .mem_2_byteenable  (m_be[2]),
        .mem_2_readdata    (m_rdata[2]),
        .mem_2_waitrequest (m_wait[2]),
        .mem_3_address     (m_addr[3]),
        .mem_3_read        (m_rd[3]),
        .mem_3_write       (m_wr[3]),
        .mem_3_writedata   (m_wdata[3]),
        .mem_3_byteenable  (m_be[3]),
        .mem_3_readdata    (m_rdata[3]),
        .mem_3_waitrequest (m_wait[3]),
        .avl_address       (avl_address),
        .avl_read          (avl_read),
        .avl_write         (avl_write),
        .avl_writedata     (avl_writedata),
        .avl_byteenable    (avl_byteenable),
        .avl_readdata      (avl_readdata),
        .avl_waitrequest   (avl_waitrequest)
    );

    function automatic line slave_data(input logic [31:0] a);
        return {a, ~a, a ^ 32'h5A5A_5A5A, 32'hC0FF_EE00};
    endfunction

    assign avl_readdata = rd_fix_en ? rd_fix : slave_data(avl_address);

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic expect_txn(input int id, input logic wr, input logic [31:0] addr,
                              input line wdata, input logic [15:0] be, input line rdata);
        exp_avl_t a;
        exp_cpl_t c;
        a.addr = addr; a.wr = wr; a.wdata = wdata; a.be = be;
        c.id = id; c.rd = !wr; c.data = rdata;
        aq.push_back(a);
        cq.push_back(c);
    endtask

    task automatic req(input int id, input logic rd, input logic wr, input logic [31:0] addr,
                       input line wdata, input logic [15:0] be);
        m_rd[id] = rd; m_wr[id] = wr; m_addr[id] = addr; m_wdata[id] = wdata; m_be[id] = be;
    endtask

    // Hold the request until its completion cycle, then release it on the next edge.
    task automatic wait_cpl(input int id);
        int  n;
        bit  seen;
        seen = 0;
        for (n = 0; n < 200 && !seen; n++) begin
            @(negedge clk);
            if (m_wait[id] === 1'b0) seen = 1;
        end
        if (!seen) chk($sformatf("timeout_master%0d", id), 0, 1);
        @(posedge clk); #1;
        m_rd[id] = 1'b0;
        m_wr[id] = 1'b0;
    endtask

    // Slave model: stall_target wait cycles per request, then accept.
    initial begin
        int cnt;
        cnt = 0;
        avl_waitrequest = 1'b1;
        forever begin
            @(negedge clk);
            if (avl_read === 1'b1 || avl_write === 1'b1) begin
                if (cnt < stall_target) begin
                    avl_waitrequest = 1'b1;
                    cnt++;
                end else begin
                    avl_waitrequest = 1'b0;
                    cnt = 0;
                end
            end else begin
                avl_waitrequest = 1'b1;
                cnt = 0;
            end
        end
    end

    // Bus monitor: compares each new request against the head of the bus queue.
    initial begin
        logic prev, act;
        exp_avl_t e;
        prev = 1'b0;
        forever begin
            @(negedge clk);
            act = (avl_read === 1'b1) || (avl_write === 1'b1);
            if (act && !prev) begin
                if (aq.size() == 0) begin
                    n_total++;
                    $display("FAIL avl_unexpected: got request addr %h expected none", avl_address);
                end else begin
                    e = aq.pop_front();
                    chk("avl_addr", avl_address, e.addr);
                    chk("avl_rw", {avl_read, avl_write}, {!e.wr, e.wr});
                    if (e.wr) begin
                        chk("avl_wdata", avl_writedata, e.wdata);
                        chk("avl_be", avl_byteenable, e.be);
                    end
                end
            end
            prev = act;
        end
    end

    // Completion monitor: exactly one master may see waitrequest low, in queue order.
    initial begin
        int nlow, who;
        exp_cpl_t e;
        forever begin
            @(negedge clk);
            nlow = 0;
            who  = 0;
            for (int n = 0; n < 4; n++) begin
                if (m_wait[n] === 1'b0) begin
                    nlow++;
                    who = n;
                end
            end
            if (nlow != 0) begin
                chk("cpl_single", nlow, 1);
                if (cq.size() == 0) begin
                    n_total++;
                    $display("FAIL cpl_unexpected: got completion for master %0d expected none", who);
                end else begin
                    e = cq.pop_front();
                    chk("cpl_id", who, e.id);
                    if (e.rd) chk("cpl_rdata", m_rdata[who], e.data);
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int ncpl, n;
        bit seen;
        rst = 1'b1;
        for (int i = 0; i < 4; i++) req(i, 1'b0, 1'b0, 32'h0, '0, 16'h0);

        // Round-robin: all four read continuously from reset.
        for (int i = 0; i < 4; i++) req(i, 1'b1, 1'b0, 32'h100 * (i + 1), '0, 16'h0);
        for (int k = 0; k < 6; k++)
            expect_txn(k % 4, 1'b0, 32'h100 * (k % 4 + 1), '0, 16'h0, slave_data(32'h100 * (k % 4 + 1)));
        @(posedge clk); @(posedge clk);
        @(negedge clk);
        chk("rst_avl_rw", {avl_read, avl_write}, 2'b00);
        chk("rst_avl_addr", avl_address, 32'h0);
        chk("rst_avl_wdata", avl_writedata, '0);
        chk("rst_avl_be", avl_byteenable, 16'h0);
        chk("rst_wait", {m_wait[3], m_wait[2], m_wait[1], m_wait[0]}, 4'hF);
        chk("rst_rdata", m_rdata[0] | m_rdata[1] | m_rdata[2] | m_rdata[3], '0);
        @(posedge clk); #1;
        rst = 1'b0;
        ncpl = 0;
        for (n = 0; n < 100 && ncpl < 6; n++) begin
            @(negedge clk);
            if (m_wait[0] === 1'b0 || m_wait[1] === 1'b0 || m_wait[2] === 1'b0 ||
                m_wait[3] === 1'b0) ncpl++;
        end
        chk("rr_count", ncpl, 6);
        @(posedge clk); #1;
        for (int i = 0; i < 4; i++) req(i, 1'b0, 1'b0, 32'h0, '0, 16'h0);
        repeat (3) @(posedge clk);
        #1;

        // Single read by master 2 with two slave wait cycles and fixed data.
        rd_fix_en    = 1'b1;
        rd_fix       = 128'hDEAD_0000_1111_2222_3333_4444_5555_BEEF;
        stall_target = 2;
        expect_txn(2, 1'b0, 32'h0000_1230, '0, 16'h0, rd_fix);
        req(2, 1'b1, 1'b0, 32'h0000_1230, '0, 16'h0);
        @(negedge clk);
        chk("t1_c0_read", avl_read, 1'b0);
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            chk($sformatf("t1_c%0d_read", c), avl_read, 1'b1);
            chk($sformatf("t1_c%0d_wait2", c), m_wait[2], 1'b1);
        end
        @(negedge clk);
        chk("t1_c4_wait2", m_wait[2], 1'b0);
        chk("t1_c4_others", {m_wait[0], m_wait[1], m_wait[3]}, 3'b111);
        @(posedge clk); #1;
        req(2, 1'b0, 1'b0, 32'h0, '0, 16'h0);
        rd_fix_en = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Write payload from master 1.
        stall_target = 1;
        expect_txn(1, 1'b1, 32'h0000_0040, 128'h1, 16'h00F0, '0);
        req(1, 1'b0, 1'b1, 32'h0000_0040, 128'h1, 16'h00F0);
        wait_cpl(1);
        repeat (2) @(posedge clk);
        #1;

        // Read and write together from master 0: treated as a write.
        stall_target = 0;
        expect_txn(0, 1'b1, 32'h0000_0080, 128'h5, 16'hFFFF, '0);
        req(0, 1'b1, 1'b1, 32'h0000_0080, 128'h5, 16'hFFFF);
        @(negedge clk); @(negedge clk);
        chk("t4_read_low", avl_read, 1'b0);
        wait_cpl(0);
        repeat (2) @(posedge clk);
        #1;

        // Reset while master 3's read is stalled; afterwards 0 wins over 3.
        stall_target = 1000;
        aq.push_back('{addr: 32'h0000_3000, wr: 1'b0, wdata: '0, be: 16'h0});
        req(3, 1'b1, 1'b0, 32'h0000_3000, '0, 16'h0);
        repeat (4) @(negedge clk);
        @(posedge clk); #1;
        rst          = 1'b1;
        stall_target = 0;
        req(0, 1'b1, 1'b0, 32'h0000_0500, '0, 16'h0);
        expect_txn(0, 1'b0, 32'h0000_0500, '0, 16'h0, slave_data(32'h0000_0500));
        expect_txn(3, 1'b0, 32'h0000_3000, '0, 16'h0, slave_data(32'h0000_3000));
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("t5_read_dropped", avl_read, 1'b0);
        chk("t5_no_pulse3", m_wait[3], 1'b1);
        wait_cpl(0);
        wait_cpl(3);
        repeat (2) @(posedge clk);
        #1;

        // Back-to-back: master 0 re-requests right after its completion.
        expect_txn(0, 1'b0, 32'h0000_0600, '0, 16'h0, slave_data(32'h0000_0600));
        expect_txn(0, 1'b0, 32'h0000_0610, '0, 16'h0, slave_data(32'h0000_0610));
        req(0, 1'b1, 1'b0, 32'h0000_0600, '0, 16'h0);
        seen = 0;
        for (n = 0; n < 50 && !seen; n++) begin
            @(negedge clk);
            if (m_wait[0] === 1'b0) seen = 1;
        end
        chk("t6_first_cpl", seen, 1'b1);
        @(posedge clk); #1;
        m_addr[0] = 32'h0000_0610;
        @(negedge clk);
        chk("t6_c1_read", avl_read, 1'b0);
        @(negedge clk);
        chk("t6_c2_read", avl_read, 1'b1);
        wait_cpl(0);

        repeat (4) @(posedge clk);
        chk("avl_queue_empty", aq.size(), 0);
        chk("cpl_queue_empty", cq.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
